ahbl_dma_copy: RTL
==================

AHBL_DMA_COPY -- requirements
Module: ahbl_dma_copy

Interface
REQ-001 HCLK  input  1  single clock for all logic.
REQ-002 HRESETn  input  1  reset, asynchronous, active-low.
REQ-003 start  input  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-004 src_addr  input  32  source byte address, sampled with start.
REQ-005 dst_addr  input  32  destination byte address, sampled with start.
REQ-006 len  input  16  number of 32-bit words to copy, sampled with start.
REQ-007 busy  output  1  high in every state other than IDLE.
REQ-008 done  output  1  one-cycle pulse at the end of a copy.
REQ-009 err  output  1  sticky error flag; set by HRESP=1, cleared by the next accepted start.
REQ-010 HADDR  output  32  AHB-Lite address.
REQ-011 HTRANS  output  2  AHB-Lite transfer type; only IDLE (00) and NONSEQ (10) are used.
REQ-012 HSIZE  output  3  constant 3'b010 (word).
REQ-013 HWRITE  output  1  AHB-Lite direction.
REQ-014 HWDATA  output  32  AHB-Lite write data.
REQ-015 HREADY  input  1  AHB-Lite bus ready.
REQ-016 HRDATA  input  32  AHB-Lite read data.
REQ-017 HRESP  input  1  AHB-Lite response; 1 = ERROR.

Function
REQ-018 FSM states SHALL be IDLE, RD_A, RD_D, WR_A, WR_D, DONE; each transfer is single and non-overlapped (no address/data pipelining between transfers).
REQ-019 IDLE SHALL behave as follows: HTRANS=00; on start=1 it latches src, dst and len with addr[1:0] forced to 00, clears err, and goes to RD_A if len!=0, otherwise to DONE.
REQ-020 RD_A SHALL drive HTRANS=10, HADDR=src, HWRITE=0, and go to RD_D on the first edge with HREADY=1.
REQ-021 RD_D SHALL behave as follows: HTRANS=00; on an edge with HREADY=1 it captures HRDATA into a 32-bit buffer and goes to WR_A.
REQ-022 WR_A SHALL drive HTRANS=10, HADDR=dst, HWRITE=1, and go to WR_D on an edge with HREADY=1.
REQ-023 WR_D SHALL behave as follows: HTRANS=00, HWDATA=buffer held stable; on an edge with HREADY=1 it does src+=4, dst+=4, count-=1, and goes to DONE if count becomes 0, otherwise to RD_A.
REQ-024 DONE SHALL assert done=1 for exactly one cycle and then go to IDLE.
REQ-025 HADDR, HTRANS and HWRITE SHALL stay stable while HREADY=0 in an address state; HWDATA SHALL stay stable throughout WR_D.
REQ-026 Latency with zero-wait slave: 4 cycles per word; start->done pulse = 4*len+1 cycles; len=0 gives done on the cycle after start with no bus transfer.
REQ-027 Address arithmetic SHALL be 32-bit modulo 2^32; incrementing from 0xFFFFFFFC wraps to 0x00000000 silently.
REQ-028 HRESP=1 seen in RD_D or WR_D SHALL set err, keep HTRANS=00, skip the remaining words, and go to DONE on the next edge, regardless of HREADY.
REQ-029 start SHALL be ignored while busy=1.
REQ-030 HSIZE SHALL be 3'b010 in all states.
REQ-031 HWRITE SHALL be 0 and HADDR SHALL hold its last value outside the WR_A and RD_A states.

Reset
REQ-032 HRESETn=0 at any time, including mid-transfer, SHALL force state=IDLE, HTRANS=00, HADDR=0, HWRITE=0, HWDATA=0, busy=0, done=0, err=0, and clear counters/buffer to 0.
REQ-033 No done pulse SHALL be generated for a copy aborted by reset.

Verification
REQ-034 Zero-wait slave, start with src=0x100, dst=0x200, len=3 -> reads 0x100/0x104/0x108 and writes 0x200/0x204/0x208 with matching data; done on cycle 13 after start; busy high cycles 1-13.
REQ-035 Slave inserts 2 wait states on every data phase, len=1 -> address/data stable during waits; done 9 cycles after start; written data equals HRDATA.
REQ-036 len=0 -> done on the next cycle; HTRANS never 10; err=0.
REQ-037 HRESP=1 on the second read of len=4 -> err=1; no write to dst+4 or beyond; done pulse follows; next start with len=1 clears err.
REQ-038 src=0xFFFFFFFC, len=2 -> second read at 0x00000000; unaligned src=0x103 -> first read at 0x100.
REQ-039 HRESETn pulsed low while in WR_A -> all outputs return to reset values immediately with no done pulse; a subsequent start runs normally; start while busy has no effect.

Source files
------------

// File: rtl/ahbl_dma_copy.sv
// Single-channel AHB-Lite word copy engine: reads one word from src, writes it
// to dst, repeats len times with non-overlapped single transfers.
module ahbl_dma_copy (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  input  logic [15:0] len,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  input  logic        HRESP
);

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 16;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD_A = 3'd1;
  localparam logic [2:0] ST_RD_D = 3'd2;
  localparam logic [2:0] ST_WR_A = 3'd3;
  localparam logic [2:0] ST_WR_D = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [31:0]   buf_q, buf_d;
  logic          err_q, err_d;
  logic [AW-1:0] haddr_q, haddr_d;
  logic [1:0]    htrans_q, htrans_d;
  logic          hwrite_q, hwrite_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d   = src_addr & ~AW'(3);
          dst_d   = dst_addr & ~AW'(3);
          cnt_d   = len;
          err_d   = 1'b0;
          state_d = (len != LW'(0)) ? ST_RD_A : ST_DONE;
        end
      end
      ST_RD_A: if (HREADY) state_d = ST_RD_D;
      ST_RD_D: begin
        if (HRESP) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (HREADY) begin
          buf_d   = HRDATA;
          state_d = ST_WR_A;
        end
      end
      ST_WR_A: if (HREADY) state_d = ST_WR_D;
      ST_WR_D: begin
        if (HRESP) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (HREADY) begin
          src_d   = src_q + AW'(4);
          dst_d   = dst_q + AW'(4);
          cnt_d   = cnt_q - LW'(1);
          state_d = (cnt_q == LW'(1)) ? ST_DONE : ST_RD_A;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus-facing outputs are decoded from the next state so they register in step with it
  always_comb begin
    htrans_d = TR_IDLE;
    hwrite_d = 1'b0;
    haddr_d  = haddr_q;
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
    if (state_d == ST_RD_A) begin
      htrans_d = TR_NONSEQ;
      haddr_d  = src_d;
    end else if (state_d == ST_WR_A) begin
      htrans_d = TR_NONSEQ;
      hwrite_d = 1'b1;
      haddr_d  = dst_d;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      cnt_q    <= '0;
      buf_q    <= '0;
      err_q    <= 1'b0;
      haddr_q  <= '0;
      htrans_q <= TR_IDLE;
      hwrite_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      cnt_q    <= cnt_d;
      buf_q    <= buf_d;
      err_q    <= err_d;
      haddr_q  <= haddr_d;
      htrans_q <= htrans_d;
      hwrite_q <= hwrite_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign HADDR  = haddr_q;
  assign HTRANS = htrans_q;
  assign HWRITE = hwrite_q;
  assign HWDATA = buf_q;
  assign HSIZE  = 3'b010;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule
